wr_port_arbiter: RTL and testbench
==================================

# wr_port_arbiter

Round-robin arbiter sharing the async FIFO write port among NUM_REQ packet sources in the write clock domain. Sits directly in front of the FIFO write-pointer/full logic: grants one requester at a time, forwards its beats as wr_en/wr_data, and honours wr_full. The grant is held for a whole packet, capped at MAX_BURST beats, so a long packet cannot starve the other sources.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- DSIZE, 8: data width, equal to the FIFO word width.
- MAX_BURST, 8: maximum beats per grant, 1..256.
- ID_W, derived: clog2(NUM_REQ), minimum 1.

- wr_clk  in  1  write-domain clock. Single clock for the whole block.
- wr_rst_n  in  1  asynchronous reset, active low.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DSIZE  per-requester beat data; lane i is bits [i*DSIZE +: DSIZE].
- req_last  in  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid.
- req_ready  out  NUM_REQ  per-requester beat accept; one-hot or zero.
- wr_full  in  1  FIFO full flag, registered in the FIFO.
- wr_en  out  1  FIFO write strobe.
- wr_data  out  DSIZE  FIFO write data.
- grant_id  out  ID_W  index of the current owner.
- busy  out  1  high while a grant is held.

## Operation
- States:
  - IDLE: no grant held.
  - OWN: grant held by grant_id.
- IDLE:
  - If any req_valid is high, pick the first set bit searching upward from last_id+1, with wrap-around.
  - Register the pick into grant_id and last_id, clear beat_cnt, go to OWN.
  - With no requests, stay in IDLE.
- OWN, combinational outputs:
  - wr_en = req_valid[grant_id] & ~wr_full.
  - req_ready[grant_id] = ~wr_full; all other req_ready bits are 0.
  - wr_data = req_data lane grant_id.
- A beat is accepted when wr_en is high.
- On each accepted beat:
  - If req_last[grant_id] is set, or beat_cnt == MAX_BURST-1, go to IDLE.
  - Otherwise increment beat_cnt.
- A forced release at MAX_BURST leaves the packet unfinished. That requester re-arbitrates normally and continues its packet when next granted; the FIFO consumer sees the packet interleaved.
- While wr_full is high: no accept, beat_cnt frozen, grant held.
- While req_valid[grant_id] is low: grant held. Requesters must finish the packet.
- busy = (state == OWN).
- beat_cnt is clog2(MAX_BURST)+1 bits wide and never exceeds MAX_BURST-1.

## Timing
- Reset values:
  - state = IDLE, grant_id = 0, last_id = NUM_REQ-1, beat_cnt = 0.
  - Hence wr_en = 0, req_ready = 0, busy = 0, and requester 0 wins the first arbitration.
- Arbitration latency: a request seen in IDLE at edge N is granted at edge N+1. The first beat can be accepted in the cycle after edge N+1.
- Each grant is followed by exactly one IDLE bubble cycle. Peak throughput is L/(L+1) for L-beat packets.
- wr_en, wr_data and req_ready are combinational from state, grant_id, req_valid, req_data and wr_full. There are no registers on the data path.
- A single-beat packet (valid and last together) returns to IDLE on the edge that accepts it.
- Asserting wr_rst_n low mid-packet returns the block to IDLE immediately. wr_en drops asynchronously. Beats already written stay in the FIFO; FIFO reset is handled separately.
- wr_full rising in the same cycle as a beat: that beat is not accepted, and the requester must hold it.

## Structure
- Package wr_arb_pkg:
  - state enum {IDLE, OWN}.
  - clog2 function.
  - Default parameter constants.
- Sub-module rr_pick: purely combinational. Inputs: request vector and last_id. Outputs: winner index and any-request flag.
- Top level holds the FSM, beat counter, grant registers and output muxes. Target size is about 150–250 lines.

## Test plan
- Reset, then req_valid=4'b0001 with a 3-beat packet (last on beat 3) -> grant_id=0 one cycle later; wr_en high for 3 consecutive cycles with data in order; busy falls after beat 3; one IDLE cycle follows.
- req_valid=4'b1111, all sources sending single-beat packets continuously -> grant order 0,1,2,3,0; each grant gives exactly 1 write then 1 bubble; no source is skipped.
- MAX_BURST=8, requester 2 sends a 20-beat packet while requester 3 waits -> 8 beats from 2, then grant to 3, then 2 resumes; beat_cnt never exceeds 7.
- wr_full held high for 5 cycles mid-packet -> wr_en=0 and req_ready=0 during the stall; grant_id unchanged; no beat lost or duplicated; the packet completes after the stall.
- Drive wr_rst_n low while requester 1 is in beat 2 of 4 -> wr_en=0 immediately; after release state=IDLE and the next grant goes to the lowest active requester starting from index 0.
- req_valid[grant_id] gaps of 3 cycles mid-packet -> grant held and busy stays 1; no other requester is granted until last is accepted.

Source files
------------

// File: rtl/wr_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package wr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DSIZE     = 8;
    localparam int DEF_MAX_BURST = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first set request bit above last_id, wrapping.
module rr_pick
    import wr_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    always_comb begin
        winner = '0;
        any    = |req;
        // Walk the offsets from farthest to nearest so the nearest hit wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            int              idx;
            logic [ID_W-1:0] idx_v;
            idx = int'(last_id) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_v = ID_W'(idx);
            if (req[idx_v]) begin
                winner = idx_v;
            end
        end
    end

endmodule

// File: rtl/wr_port_arbiter.sv
// Round-robin owner of the async FIFO write port; a grant lasts one packet,
// capped at MAX_BURST beats, and is always followed by one idle cycle.
module wr_port_arbiter
    import wr_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DSIZE     = DEF_DSIZE,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int ID_W      = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
    input  logic                     wr_clk,
    input  logic                     wr_rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*DSIZE-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     wr_full,
    output logic                     wr_en,
    output logic [DSIZE-1:0]         wr_data,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy
);

    localparam int CNT_W = clog2(MAX_BURST) + 1;

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_OWN  = OWN;

    // Handshake: a beat moves on a cycle where req_valid and req_ready of the
    // owner are both high, which is exactly when wr_en is high. A requester
    // holding valid must keep data/last stable until that cycle.

    logic [0:0]       state;
    logic [ID_W-1:0]  last_id;
    logic [ID_W-1:0]  pick_id;
    logic [CNT_W-1:0] beat_cnt;
    logic             any_req;
    logic             own;
    logic             end_beat;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (req_valid),
        .last_id (last_id),
        .winner  (pick_id),
        .any     (any_req)
    );

    assign own      = (state == ST_OWN);
    assign busy     = own;
    assign wr_en    = own & req_valid[grant_id] & ~wr_full;
    assign end_beat = req_last[grant_id] | (beat_cnt == CNT_W'(MAX_BURST - 1));

    always_comb begin
        req_ready = '0;
        wr_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                wr_data      = req_data[i*DSIZE +: DSIZE];
                req_ready[i] = own & ~wr_full;
            end
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            last_id  <= ID_W'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_id <= pick_id;
                        last_id  <= pick_id;
                        beat_cnt <= '0;
                        state    <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    // A capped release leaves the packet open; the source re-arbitrates.
                    if (wr_en) begin
                        if (end_beat) begin
                            state <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Bench for wr_port_arbiter: directed vector table, mid-packet reset, burst cap
// sequence and a randomized run checked against a transaction-level model.
module tb_wr_port_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DSIZE     = 8;
    localparam int MAX_BURST = 8;
    localparam int ID_W      = 2;

    logic                     wr_clk;
    logic                     wr_rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*DSIZE-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     wr_full;
    logic                     wr_en;
    logic [DSIZE-1:0]         wr_data;
    logic [ID_W-1:0]          grant_id;
    logic                     busy;

    wr_port_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DSIZE     (DSIZE),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wr_clk    (wr_clk),
        .wr_rst_n  (wr_rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wr_full   (wr_full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- source model and scoreboard ----------------
    logic [DSIZE:0]     src_q[NUM_REQ][$];
    logic [DSIZE-1:0]   exp_q[NUM_REQ][$];
    int                 seq_no[NUM_REQ];
    logic [NUM_REQ-1:0] shown;
    logic [NUM_REQ-1:0] accepted;
    bit                 mon_en, src_en, gap_mode, full_mode;
    int                 stall_left;

    int                 model_last;
    bit                 prev_busy, prev_acc, prev_end;
    logic [NUM_REQ-1:0] prev_req;
    logic [ID_W-1:0]    prev_grant;
    int                 cur_beats;
    int                 grant_log[$];

    function automatic int rr_model(input logic [NUM_REQ-1:0] req, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (req[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic add_packet(input int src, input int len);
        for (int b = 0; b < len; b++) begin
            logic [DSIZE-1:0] d;
            d = DSIZE'(src * 64 + (seq_no[src] % 64));
            seq_no[src]++;
            src_q[src].push_back({(b == len - 1) ? 1'b1 : 1'b0, d});
            exp_q[src].push_back(d);
        end
    endtask

    function automatic bit all_done();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic monitor();
        logic [NUM_REQ-1:0] exp_ready;
        logic [DSIZE-1:0]   lane;
        bit                 acc, end_now;
        int                 g;
        accepted = '0;
        acc      = 1'b0;
        end_now  = 1'b0;
        if (!prev_busy) begin
            if (prev_req != '0) begin
                g = rr_model(prev_req, model_last);
                chk("arb_busy", 32'(busy), 32'd1);
                chk("arb_grant", 32'(grant_id), 32'(g));
                model_last = g;
                cur_beats  = 0;
            end else begin
                chk("idle_stay", 32'(busy), 32'd0);
            end
        end else begin
            chk("hold_release", 32'(busy), 32'((prev_acc && prev_end) ? 0 : 1));
            if (busy) chk("grant_hold", 32'(grant_id), 32'(prev_grant));
        end
        g = int'(grant_id);
        chk("wr_en_rule", 32'(wr_en), 32'(busy && req_valid[g] && !wr_full));
        exp_ready = (busy && !wr_full) ? NUM_REQ'(1 << g) : '0;
        chk("ready_rule", 32'(req_ready), 32'(exp_ready));
        if (busy) begin
            lane = req_data[g*DSIZE +: DSIZE];
            chk("wr_data_lane", 32'(wr_data), 32'(lane));
        end
        if (wr_en) begin
            acc = 1'b1;
            chk("sb_nonempty", 32'(exp_q[g].size() > 0), 32'd1);
            if (exp_q[g].size() > 0) begin
                chk("sb_data", 32'(wr_data), 32'(exp_q[g][0]));
                void'(exp_q[g].pop_front());
            end
            accepted[g] = 1'b1;
            cur_beats++;
            chk("burst_cap", 32'(cur_beats <= MAX_BURST), 32'd1);
            end_now = req_last[g] || (cur_beats == MAX_BURST);
            if (end_now) grant_log.push_back(g * 256 + cur_beats);
        end
        prev_busy  = busy;
        prev_req   = req_valid;
        prev_grant = grant_id;
        prev_acc   = acc;
        prev_end   = end_now;
    endtask

    task automatic drive_sources();
        logic [DSIZE:0] tmp;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accepted[i]) begin
                if (src_q[i].size() > 0) tmp = src_q[i].pop_front();
                shown[i] = 1'b0;
            end
            if (!shown[i] && src_q[i].size() > 0)
                shown[i] = gap_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            req_valid[i] = shown[i];
            if (src_q[i].size() > 0) begin
                req_data[i*DSIZE +: DSIZE] = src_q[i][0][DSIZE-1:0];
                req_last[i] = src_q[i][0][DSIZE];
            end else begin
                req_data[i*DSIZE +: DSIZE] = '0;
                req_last[i] = 1'b0;
            end
        end
        if (!full_mode) begin
            wr_full = 1'b0;
        end else if (stall_left > 0) begin
            wr_full = 1'b1;
            stall_left--;
        end else if ($urandom_range(0, 29) == 0) begin
            wr_full = 1'b1;
            stall_left = 4;
        end else begin
            wr_full = ($urandom_range(0, 9) == 0);
        end
    endtask

    task automatic step();
        @(negedge wr_clk);
        if (mon_en) monitor();
        @(posedge wr_clk);
        #1;
        if (src_en) drive_sources();
    endtask

    task automatic reset_dut();
        mon_en = 0; src_en = 0; gap_mode = 0; full_mode = 0;
        req_valid = '0; req_last = '0; req_data = '0; wr_full = 1'b0;
        wr_rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            seq_no[i] = 0;
        end
        shown = '0; accepted = '0; stall_left = 0;
        model_last = NUM_REQ - 1;
        prev_busy = 0; prev_acc = 0; prev_end = 0; prev_req = '0; prev_grant = '0;
        cur_beats = 0;
        grant_log.delete();
        repeat (3) @(posedge wr_clk);
        @(negedge wr_clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        wr_rst_n = 1'b1;
        @(posedge wr_clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [NUM_REQ-1:0]       valid;
        logic [NUM_REQ-1:0]       last;
        logic                     full;
        logic [NUM_REQ*DSIZE-1:0] data;
        logic                     e_busy;
        logic [ID_W-1:0]          e_grant;
        logic                     e_wr_en;
        logic [NUM_REQ-1:0]       e_ready;
        logic [DSIZE-1:0]         e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic mk(input logic [3:0] v, input logic [3:0] l, input logic f, input logic [31:0] d,
                      input logic eb, input logic [1:0] eg, input logic ew, input logic [3:0] er,
                      input logic [7:0] ed);
        vec_t t;
        t.valid = v; t.last = l; t.full = f; t.data = d;
        t.e_busy = eb; t.e_grant = eg; t.e_wr_en = ew; t.e_ready = er; t.e_data = ed;
        vecs.push_back(t);
    endtask

    initial begin
        int cyc;
        wr_rst_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; wr_full = 1'b0;

        // 3-beat packet from 0, round robin of single beats, stall, valid gap.
        mk(4'b0001, 4'b0000, 0, 32'h00000011, 0, 0, 0, 4'b0000, 8'h00);
        mk(4'b0001, 4'b0000, 0, 32'h00000011, 1, 0, 1, 4'b0001, 8'h11);
        mk(4'b0001, 4'b0000, 0, 32'h00000022, 1, 0, 1, 4'b0001, 8'h22);
        mk(4'b0001, 4'b0001, 0, 32'h00000033, 1, 0, 1, 4'b0001, 8'h33);
        mk(4'b0000, 4'b0000, 0, 32'h00000000, 0, 0, 0, 4'b0000, 8'h00);
        mk(4'b1111, 4'b1111, 0, 32'h44332211, 0, 0, 0, 4'b0000, 8'h00);
        mk(4'b1111, 4'b1111, 0, 32'h44332211, 1, 1, 1, 4'b0010, 8'h22);
        mk(4'b1111, 4'b1111, 0, 32'h44332211, 0, 1, 0, 4'b0000, 8'h00);
        mk(4'b1111, 4'b1111, 0, 32'h44332211, 1, 2, 1, 4'b0100, 8'h33);
        mk(4'b1111, 4'b1111, 0, 32'h44332211, 0, 2, 0, 4'b0000, 8'h00);
        mk(4'b1111, 4'b1111, 0, 32'h44332211, 1, 3, 1, 4'b1000, 8'h44);
        mk(4'b1111, 4'b1111, 0, 32'h44332211, 0, 3, 0, 4'b0000, 8'h00);
        mk(4'b1111, 4'b1111, 0, 32'h44332211, 1, 0, 1, 4'b0001, 8'h11);
        mk(4'b0010, 4'b0000, 0, 32'h0000A100, 0, 0, 0, 4'b0000, 8'h00);
        mk(4'b0010, 4'b0000, 1, 32'h0000A100, 1, 1, 0, 4'b0000, 8'hA1);
        mk(4'b0010, 4'b0000, 0, 32'h0000A100, 1, 1, 1, 4'b0010, 8'hA1);
        mk(4'b0000, 4'b0000, 0, 32'h00000000, 1, 1, 0, 4'b0010, 8'h00);
        mk(4'b0011, 4'b0010, 0, 32'h0000A205, 1, 1, 1, 4'b0010, 8'hA2);
        mk(4'b0001, 4'b0001, 0, 32'h00000005, 0, 1, 0, 4'b0000, 8'h00);
        mk(4'b0001, 4'b0001, 0, 32'h00000005, 1, 0, 1, 4'b0001, 8'h05);
        mk(4'b0000, 4'b0000, 0, 32'h00000000, 0, 0, 0, 4'b0000, 8'h00);

        reset_dut();
        foreach (vecs[n]) begin
            req_valid = vecs[n].valid;
            req_last  = vecs[n].last;
            wr_full   = vecs[n].full;
            req_data  = vecs[n].data;
            @(negedge wr_clk);
            chk($sformatf("vec%0d_busy", n), 32'(busy), 32'(vecs[n].e_busy));
            chk($sformatf("vec%0d_grant", n), 32'(grant_id), 32'(vecs[n].e_grant));
            chk($sformatf("vec%0d_wr_en", n), 32'(wr_en), 32'(vecs[n].e_wr_en));
            chk($sformatf("vec%0d_ready", n), 32'(req_ready), 32'(vecs[n].e_ready));
            if (vecs[n].e_busy)
                chk($sformatf("vec%0d_data", n), 32'(wr_data), 32'(vecs[n].e_data));
            @(posedge wr_clk);
            #1;
        end

        // Reset while requester 1 is presenting beat 2 of 4.
        reset_dut();
        req_valid = 4'b0010; req_data = 32'h0000B100; req_last = '0;
        @(posedge wr_clk); #1;
        @(negedge wr_clk);
        chk("mr_beat1", 32'(wr_en), 32'd1);
        @(posedge wr_clk); #1;
        req_data = 32'h0000B200;
        @(negedge wr_clk);
        chk("mr_beat2", 32'(wr_en), 32'd1);
        #2 wr_rst_n = 1'b0;
        #1;
        chk("mr_async_wr_en", 32'(wr_en), 32'd0);
        chk("mr_async_busy", 32'(busy), 32'd0);
        chk("mr_async_ready", 32'(req_ready), 32'd0);
        chk("mr_async_grant", 32'(grant_id), 32'd0);
        @(posedge wr_clk);
        @(posedge wr_clk);
        @(negedge wr_clk);
        wr_rst_n = 1'b1;
        req_valid = 4'b1010;
        req_data  = 32'hD100C100;
        #1;
        chk("mr_idle_after", 32'(busy), 32'd0);
        @(posedge wr_clk); #1;
        @(negedge wr_clk);
        chk("mr_regrant_busy", 32'(busy), 32'd1);
        chk("mr_regrant_id", 32'(grant_id), 32'd1);

        // Requester 2 sends 20 beats while 3 waits with a 4-beat packet.
        reset_dut();
        mon_en = 1; src_en = 1;
        add_packet(2, 20);
        step();
        step();
        add_packet(3, 4);
        cyc = 0;
        while (!all_done() && cyc < 300) begin
            step();
            cyc++;
        end
        chk("burst_timeout", 32'(all_done()), 32'd1);
        chk("burst_log_len", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            chk("burst_g0", 32'(grant_log[0]), 32'(2 * 256 + 8));
            chk("burst_g1", 32'(grant_log[1]), 32'(3 * 256 + 4));
            chk("burst_g2", 32'(grant_log[2]), 32'(2 * 256 + 8));
            chk("burst_g3", 32'(grant_log[3]), 32'(2 * 256 + 4));
        end

        // Randomized traffic with valid gaps and wr_full stalls.
        reset_dut();
        mon_en = 1; src_en = 1; gap_mode = 1; full_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0)
                    add_packet(i, $urandom_range(1, 12));
            end
            step();
        end
        cyc = 0;
        while (!all_done() && cyc < 3000) begin
            step();
            cyc++;
        end
        chk("rand_drain", 32'(all_done()), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
